// File: rtl/fetch_prefetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_unit_pkg
// Purpose  : Shared fetch constants and the branch-target helper used by IF/EX.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_prefetch_unit_pkg;

    localparam int          INST_W   = 32;
    localparam int          PC_INC   = 4;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam int          PC_MAX_W = 64;

    // Computed at the widest supported PC width; callers truncate, which
    // yields the modulo-2^PC_W wrap.
    function automatic logic [PC_MAX_W-1:0] branch_target(
        input logic [PC_MAX_W-1:0] br_pc,
        input logic [15:0]         imm16
    );
        logic [PC_MAX_W-1:0] offset;
        logic [PC_MAX_W-1:0] target;
        offset = {{(PC_MAX_W-18){imm16[15]}}, imm16, 2'b00};
        target = br_pc + PC_MAX_W'(PC_INC) + offset;
        target[1:0] = 2'b00;
        return target;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_unit_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Synchronous FIFO of {pc, inst} entries with push, pop and flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_push_data,
    output logic [WIDTH-1:0]           o_head_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push = i_push && (r_count != c_CNT_W'(DEPTH));
    assign w_pop  = i_pop  && (r_count != '0);

    // Flush outranks push and pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_unit
// Purpose  : Credit-limited in-order instruction fetch with a prefetch queue.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [15:0]       br_imm16,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              id_ready
);

    localparam int c_CNT_W   = $clog2(DEPTH) + 1;
    localparam int c_ENTRY_W = PC_W + INST_W;

    logic [PC_W-1:0]      r_fetch_pc;
    logic [PC_W-1:0]      r_resp_pc;
    logic [c_CNT_W-1:0]   r_outstanding;
    logic [c_CNT_W-1:0]   r_drop_cnt;
    logic [c_CNT_W-1:0]   w_count;
    logic [c_CNT_W:0]     w_credit_used;
    logic [c_CNT_W-1:0]   w_inflight_left;
    logic [c_ENTRY_W-1:0] w_head_data;
    logic [PC_W-1:0]      w_target;
    logic                 w_issue;
    logic                 w_drop;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_head_valid;

    assign w_target = PC_W'(branch_target(PC_MAX_W'(br_pc), br_imm16));

    assign w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_issue = !reset && !br_taken
                   && (w_credit_used < (c_CNT_W+1)'(DEPTH))
                   && (r_outstanding < c_CNT_W'(MAX_OUT));

    assign w_drop          = imem_rvalid && (r_drop_cnt != '0);
    assign w_push          = imem_rvalid && !w_drop && !br_taken && !reset;
    assign w_pop           = w_head_valid && id_ready;
    assign w_inflight_left = r_outstanding - c_CNT_W'(imem_rvalid);

    // Reset and redirect both orphan every request still in flight, so the
    // outstanding count survives and all of it becomes drop credit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= w_inflight_left;
            r_drop_cnt    <= w_inflight_left;
        end else if (br_taken) begin
            r_fetch_pc    <= w_target;
            r_resp_pc     <= w_target;
            r_outstanding <= w_inflight_left;
            r_drop_cnt    <= w_inflight_left;
        end else begin
            if (w_issue) r_fetch_pc <= r_fetch_pc + PC_W'(PC_INC);
            if (w_push)  r_resp_pc  <= r_resp_pc + PC_W'(PC_INC);
            if (w_drop)  r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
            r_outstanding <= w_inflight_left + c_CNT_W'(w_issue);
        end
    end

    fetch_queue #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_flush     (br_taken),
        .i_push_data ({r_resp_pc, imem_rdata}),
        .o_head_data (w_head_data),
        .o_count     (w_count)
    );

    assign imem_req     = w_issue;
    assign imem_addr    = r_fetch_pc;
    assign w_head_valid = !reset && (w_count != '0);
    assign inst_valid   = w_head_valid;
    assign inst         = w_head_valid ? w_head_data[INST_W-1:0] : NOP;
    assign inst_pc      = w_head_valid ? w_head_data[c_ENTRY_W-1:INST_W] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch_unit
// Purpose  : Directed self-checking bench for fetch_prefetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [15:0] br_imm16;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        id_ready;

    logic        rst_w;
    logic        req_w;
    logic [31:0] addr_w;
    logic        rvalid_w;
    logic [31:0] rdata_w;
    logic        inst_valid_w;
    logic [31:0] inst_w;
    logic [31:0] inst_pc_w;
    logic        req_w_lat;
    logic [31:0] addr_w_lat;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int mem_lat      = 1;
    bit inv_on       = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    always #5 clk = ~clk;

    fetch_prefetch_unit u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .br_taken    (br_taken),
        .br_pc       (br_pc),
        .br_imm16    (br_imm16),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .id_ready    (id_ready)
    );

    fetch_prefetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk         (clk),
        .reset       (rst_w),
        .imem_req    (req_w),
        .imem_addr   (addr_w),
        .imem_rvalid (rvalid_w),
        .imem_rdata  (rdata_w),
        .br_taken    (1'b0),
        .br_pc       (32'h0),
        .br_imm16    (16'h0),
        .inst_valid  (inst_valid_w),
        .inst        (inst_w),
        .inst_pc     (inst_pc_w),
        .id_ready    (1'b1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Fixed-latency in-order memory for the main instance.
    always @(negedge clk) begin
        if (imem_req) pend.push_back('{addr: imem_addr, due: cyc + mem_lat});
    end

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // Latency-1 memory for the wrap-around instance.
    always @(negedge clk) begin
        req_w_lat  = req_w;
        addr_w_lat = addr_w;
    end

    always @(posedge clk) begin
        #1;
        rvalid_w = req_w_lat;
        rdata_w  = req_w_lat ? mem_word(addr_w_lat) : 32'h0;
    end

    always @(negedge clk) begin
        if (inv_on) begin
            tests_run = tests_run + 3;
            if (imem_rvalid && u_dut.r_outstanding == 0) begin
                tests_failed++;
                $display("FAIL inv_rvalid_idle: rvalid=1 with outstanding=%0d, required >0", u_dut.r_outstanding);
            end
            if (u_dut.w_count > 4) begin
                tests_failed++;
                $display("FAIL inv_count: count=%0d, required <=4", u_dut.w_count);
            end
            if (u_dut.r_drop_cnt > u_dut.r_outstanding) begin
                tests_failed++;
                $display("FAIL inv_drop: drop_cnt=%0d, required <= outstanding=%0d", u_dut.r_drop_cnt, u_dut.r_outstanding);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        reset    = 1'b1;
        br_taken = 1'b0;
        br_pc    = 32'h0;
        br_imm16 = 16'h0;
        id_ready = 1'b0;
        repeat (5) next_cycle();
        mem_lat = lat;
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) next_cycle();
        inv_on = 1'b1;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b, required 0", imem_req); end
        tests_run++;
        if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", inst_valid); end
        tests_run++;
        if (inst !== 32'h0) begin tests_failed++; $display("FAIL reset_inst: got %h, required 0", inst); end
        tests_run++;
        if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h, required 0", inst_pc); end
        next_cycle();
    endtask

    task automatic test_straight_line();
        do_reset(1);
        id_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin
                tests_failed++;
                $display("FAIL straight_req c%0d: got req=%b addr=%h, required 1/%h", c, imem_req, imem_addr, 32'(4 * c));
            end
            tests_run++;
            if (c < 2) begin
                if (inst_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL straight_fill c%0d: got valid=%b, required 0", c, inst_valid);
                end
            end else if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (c - 2)) || inst !== mem_word(32'(4 * (c - 2)))) begin
                tests_failed++;
                $display("FAIL straight_head c%0d: got %b/%h/%h, required 1/%h/%h", c, inst_valid, inst_pc, inst,
                         32'(4 * (c - 2)), mem_word(32'(4 * (c - 2))));
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        int n_req;
        n_req = 0;
        do_reset(1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req) n_req++;
            if (c >= 4) begin
                tests_run++;
                if (imem_req !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bp_no_req c%0d: got req=%b, required 0", c, imem_req);
                end
            end
            if (c >= 2) begin
                tests_run++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== mem_word(32'h0)) begin
                    tests_failed++;
                    $display("FAIL bp_hold c%0d: got %b/%h/%h, required 1/0/%h", c, inst_valid, inst_pc, inst, mem_word(32'h0));
                end
            end
            next_cycle();
        end
        tests_run++;
        if (n_req !== 4) begin tests_failed++; $display("FAIL bp_req_count: got %0d, required 4", n_req); end
        id_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL bp_pop_head: got %h, required 0", inst_pc); end
        next_cycle();
        id_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || inst_pc !== 32'h4) begin
            tests_failed++;
            $display("FAIL bp_after_pop: got req=%b addr=%h pc=%h, required 1/10/4", imem_req, imem_addr, inst_pc);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL bp_refull: got req=%b, required 0", imem_req); end
        next_cycle();
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] exp_pc [5] = '{32'h0, 32'h0, 32'h0, 32'h1C, 32'h20};
        do_reset(3);
        id_ready = 1'b1;
        repeat (3) next_cycle();
        br_taken = 1'b1;
        br_pc    = 32'h20;
        br_imm16 = 16'hFFFE;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL redir_no_issue: got %b, required 0", imem_req); end
        next_cycle();
        br_taken = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h1C) begin
            tests_failed++;
            $display("FAIL redir_target: got req=%b addr=%h, required 1/1c", imem_req, imem_addr);
        end
        for (int c = 4; c < 10; c++) begin
            if (c > 4) @(negedge clk);
            tests_run++;
            if (c < 8) begin
                if (inst_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL redir_dropped c%0d: got valid=%b pc=%h, required 0", c, inst_valid, inst_pc);
                end
            end else if (inst_valid !== 1'b1 || inst_pc !== exp_pc[c-5] || inst !== mem_word(exp_pc[c-5])) begin
                tests_failed++;
                $display("FAIL redir_head c%0d: got %b/%h/%h, required 1/%h/%h", c, inst_valid, inst_pc, inst,
                         exp_pc[c-5], mem_word(exp_pc[c-5]));
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect_with_pop();
        do_reset(2);
        id_ready = 1'b1;
        repeat (4) next_cycle();
        br_taken = 1'b1;
        br_pc    = 32'h100;
        br_imm16 = 16'h0010;
        @(negedge clk);
        tests_run++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rp_branch_cycle: got valid=%b pc=%h req=%b, required 1/4/0", inst_valid, inst_pc, imem_req);
        end
        next_cycle();
        br_taken = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h144 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rp_target: got req=%b addr=%h valid=%b, required 1/144/0", imem_req, imem_addr, inst_valid);
        end
        tests_run++;
        if (u_dut.r_drop_cnt !== 3'd1) begin
            tests_failed++;
            $display("FAIL rp_drop_cnt: got %0d, required 1", u_dut.r_drop_cnt);
        end
        next_cycle();
        for (int c = 6; c < 10; c++) begin
            @(negedge clk);
            tests_run++;
            if (c < 8) begin
                if (inst_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rp_flushed c%0d: got valid=%b pc=%h, required 0", c, inst_valid, inst_pc);
                end
            end else if (inst_valid !== 1'b1 || inst_pc !== (c == 8 ? 32'h144 : 32'h148)) begin
                tests_failed++;
                $display("FAIL rp_head c%0d: got %b/%h, required 1/%h", c, inst_valid, inst_pc, (c == 8 ? 32'h144 : 32'h148));
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        rst_w = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (req_w !== 1'b1 || addr_w !== exp_addr[c]) begin
                tests_failed++;
                $display("FAIL wrap_addr c%0d: got req=%b addr=%h, required 1/%h", c, req_w, addr_w, exp_addr[c]);
            end
            if (c >= 2) begin
                tests_run++;
                if (inst_valid_w !== 1'b1 || inst_pc_w !== exp_addr[c-2] || inst_w !== mem_word(exp_addr[c-2])) begin
                    tests_failed++;
                    $display("FAIL wrap_head c%0d: got %b/%h/%h, required 1/%h", c, inst_valid_w, inst_pc_w, inst_w, exp_addr[c-2]);
                end
            end
            next_cycle();
        end
        rst_w = 1'b1;
    endtask

    task automatic test_reset_midop();
        do_reset(3);
        id_ready = 1'b1;
        repeat (2) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got req=%b valid=%b inst=%h pc=%h, required all 0", imem_req, inst_valid, inst, inst_pc);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_restart: got req=%b addr=%h, required 1/0", imem_req, imem_addr);
        end
        for (int c = 3; c < 9; c++) begin
            if (c > 3) @(negedge clk);
            tests_run++;
            if (c < 7) begin
                if (inst_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL mid_late_resp c%0d: got valid=%b pc=%h, required 0", c, inst_valid, inst_pc);
                end
            end else if (inst_valid !== 1'b1 || inst_pc !== (c == 7 ? 32'h0 : 32'h4)) begin
                tests_failed++;
                $display("FAIL mid_head c%0d: got %b/%h, required 1/%h", c, inst_valid, inst_pc, (c == 7 ? 32'h0 : 32'h4));
            end
            next_cycle();
        end
    endtask

    initial begin
        reset    = 1'b1;
        rst_w    = 1'b1;
        br_taken = 1'b0;
        br_pc    = 32'h0;
        br_imm16 = 16'h0;
        id_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        rvalid_w    = 1'b0;
        rdata_w     = 32'h0;
        next_cycle();
        test_reset();
        test_straight_line();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_with_pop();
        test_wrap();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
